// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. A single 1-bit full-adder
// cell is reused once per clock, LSB first, to form A+B+Cin over WIDTH
// cycles. The FSM runs IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
//
// Optional feature macro: SERIAL_ADD_SUB_EN adds input Sub; Sub=1 computes
// A-B as A+~B+1 (Cin ignored), and Ca=1 then means "no borrow".
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   begin one operation (accepted only in IDLE)
//   A, B   in   WIDTH-bit operands, captured on accepted start
//   Cin    in   carry-in, captured on accepted start
//   Sub    in   (SERIAL_ADD_SUB_EN only) subtract select, captured on start
//   busy   out  high while in RUN
//   done   out  one-cycle pulse while in DONE; Sum/Ca valid
//   Sum    out  registered WIDTH-bit result, held until next accepted start
//   Ca     out  registered carry-out of bit WIDTH-1

module serial_add_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Ca
);

  // cnt must reach WIDTH after the last bit without wrapping, hence +1 bit.
  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             c_r;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic             last, ld;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  assign idx  = cnt[IW-1:0];
  assign last = (cnt == CW'(WIDTH - 1));

  // Subtraction folds into the add path: invert B and force carry-in to 1
  // at capture time, so the serial datapath stays identical.
`ifdef SERIAL_ADD_SUB_EN
  assign b_in = Sub ? ~B : B;
  assign c_in = Sub ? 1'b1 : Cin;
`else
  assign b_in = B;
  assign c_in = Cin;
`endif

  serial_add_fa u_fa (
    .a  (a_r[idx]),
    .b  (b_r[idx]),
    .ci (c_r),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    ld       = 1'b0;
    case (state)
      IDLE: if (start) begin
        ld       = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= 1'b0;
      cnt <= '0;
      Sum <= '0;
      Ca  <= 1'b0;
    end else if (ld) begin
      a_r <= A;
      b_r <= b_in;
      c_r <= c_in;
      cnt <= '0;
    end else if (busy) begin
      Sum[idx] <= fa_s;
      c_r      <= fa_co;
      cnt      <= cnt + CW'(1);
      if (last) Ca <= fa_co;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, ca;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .Sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Ca    (ca)
  );

  // Launch one op from a falling edge; returns at the first falling edge
  // inside RUN with start already dropped.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, ca} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b sum=%h ca=%b want 0 0 00 0", busy, done, sum, ca);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n = 0, bc = 0;
    launch(8'h0F, 8'h01, 1'b0);
    while (!done && n < 20) begin
      if (busy) bc++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 8 || bc !== 8) begin
      failures++;
      $display("FAIL basic_latency got run_cycles=%0d busy_cycles=%0d want 8 8", n, bc);
    end
    checks++;
    if (sum !== 8'h10 || ca !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got sum=%h ca=%b busy=%b want 10 0 0", sum, ca, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_overflow_hold();
    int n = 0;
    logic bad = 1'b0;
    launch(8'hFF, 8'h00, 1'b1);
    while (!done && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (done !== 1'b1 || sum !== 8'h00 || ca !== 1'b1) begin
      failures++;
      $display("FAIL overflow_result got done=%b sum=%h ca=%b want 1 00 1", done, sum, ca);
    end
    a = 8'h5A; b = 8'hA5;
    repeat (20) begin
      @(negedge clk);
      if (sum !== 8'h00 || ca !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle_hold got sum=%h ca=%b (some idle cycle differed) want 00 1", sum, ca);
    end
  endtask

  task automatic test_ignore_start();
    int dcnt = 0;
    logic [W-1:0] dsum = '0;
    logic dca = 1'b0;
    launch(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;   // RUN cycle 3
    @(negedge clk);
    start = 1'b0;
    repeat (20) begin
      if (done) begin dcnt++; dsum = sum; dca = ca; end
      @(negedge clk);
    end
    checks++;
    if (dcnt !== 1) begin
      failures++;
      $display("FAIL ignore_done_count got %0d want 1", dcnt);
    end
    checks++;
    if (dsum !== 8'h46 || dca !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result got sum=%h ca=%b want 46 0", dsum, dca);
    end
  endtask

  task automatic test_abort();
    int dcnt = 0, n = 0;
    launch(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);            // RUN cycle 4
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sum, ca} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL abort_async got busy=%b done=%b sum=%h ca=%b want 0 0 00 0", busy, done, sum, ca);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      if (done || busy) dcnt++;
      @(negedge clk);
    end
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL abort_no_done got active_cycles=%0d want 0", dcnt);
    end
    launch(8'h01, 8'h02, 1'b0);
    while (!done && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (done !== 1'b1 || sum !== 8'h03 || ca !== 1'b0) begin
      failures++;
      $display("FAIL after_abort got done=%b sum=%h ca=%b want 1 03 0", done, sum, ca);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pos[$];
    logic bad_sum = 1'b0;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        pos.push_back(k);
        if (sum !== 8'h02 || ca !== 1'b0) bad_sum = 1'b1;
      end
    end
    start = 1'b0;
    checks++;
    if (pos.size() !== 3) begin
      failures++;
      $display("FAIL b2b_count got %0d want 3", pos.size());
    end else begin
      checks++;
      if (pos[0] !== 9 || pos[1] - pos[0] !== 10 || pos[2] - pos[1] !== 10) begin
        failures++;
        $display("FAIL b2b_spacing got %0d %0d %0d want 9 19 29", pos[0], pos[1], pos[2]);
      end
    end
    checks++;
    if (bad_sum) begin
      failures++;
      $display("FAIL b2b_sum got a done with sum!=02 (last sum=%h) want 02", sum);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int n = 0;
    sub = 1'b1;
    launch(8'h05, 8'h07, 1'b0);
    sub = 1'b0;
    while (!done && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (done !== 1'b1 || sum !== 8'hFE || ca !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow got done=%b sum=%h ca=%b want 1 FE 0", done, sum, ca);
    end
    @(negedge clk);
    n = 0;
    sub = 1'b1;
    launch(8'h07, 8'h05, 1'b0);
    sub = 1'b0;
    while (!done && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (done !== 1'b1 || sum !== 8'h02 || ca !== 1'b1) begin
      failures++;
      $display("FAIL sub_noborrow got done=%b sum=%h ca=%b want 1 02 1", done, sum, ca);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow_hold();
    test_ignore_start();
    test_abort();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 SHALL have port A  input  WIDTH  operand A; captured only on an accepted start.
REQ-006 SHALL have port B  input  WIDTH  operand B; captured only on an accepted start.
REQ-007 SHALL have port Cin  input  1  carry-in for bit 0; captured only on an accepted start.
REQ-008 SHALL have port busy  output  1  high while the serial add is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking Sum/Ca valid.
REQ-010 SHALL have port Sum  output  WIDTH  registered result.
REQ-011 SHALL have port Ca  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-012 SHALL compute A+B+Cin using exactly one internal 1-bit full-adder cell, reused once per cycle, LSB first.
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at edge T0 SHALL latch A, B and Cin into internal registers, clear the bit counter to 0, and move the FSM to RUN.
REQ-015 RUN: each edge SHALL write bit[cnt] of the cell sum into Sum[cnt], store the cell carry, and increment cnt; the edge that commits bit WIDTH-1 (T0+WIDTH) SHALL load Ca and move the FSM to DONE.
REQ-016 DONE: the FSM SHALL return to IDLE at the next edge (T0+WIDTH+1).
REQ-017 busy SHALL be 1 exactly when the FSM is in RUN.
REQ-018 done SHALL be 1 exactly when the FSM is in DONE, i.e. the cycle after edge T0+WIDTH.
REQ-019 start SHALL be ignored in RUN and DONE; operand changes after capture SHALL NOT affect the result.
REQ-020 start held high continuously SHALL begin a new operation on the edge following the DONE cycle; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-021 Sum and Ca SHALL hold the last completed result in IDLE until the next accepted start.
REQ-022 During RUN, Sum bits at index >= cnt are unspecified to observers; only values at done=1 are checked.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH with the overflow bit on Ca, e.g. all-ones + 1 gives Sum=0, Ca=1.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH)) bits wide plus one and SHALL NOT wrap within an operation.

Reset
REQ-025 rst=1 SHALL immediately force FSM=IDLE, cnt=0, Sum=0, Ca=0, busy=0, done=0, and all internal operand/carry registers to 0, independent of clk.
REQ-026 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.
REQ-027 start sampled on the same edge that rst deasserts SHALL be accepted.

Configuration
REQ-028 Macro SERIAL_ADD_SUB_EN, when defined, SHALL add input port Sub (1 bit, captured with the operands); Sub=1 SHALL compute A-B as A+~B+1, ignoring Cin, with Ca=1 meaning no borrow.
REQ-029 Without SERIAL_ADD_SUB_EN, port Sub SHALL NOT exist and the block SHALL perform addition only.

Verification (WIDTH=8)
REQ-030 Reset, then A=8'h0F, B=8'h01, Cin=0, start pulse -> busy for 8 cycles, done at T0+9 cycle, Sum=8'h10, Ca=0.
REQ-031 A=8'hFF, B=8'h00, Cin=1 -> Sum=8'h00, Ca=1; Sum/Ca unchanged for 20 idle cycles afterwards.
REQ-032 Start A=8'h12, B=8'h34, then at RUN cycle 3 pulse start with A=8'hFF, B=8'hFF -> single done, Sum=8'h46, Ca=0; second start ignored.
REQ-033 Start A=8'hAA, B=8'h55; assert rst at RUN cycle 4 -> outputs 0 immediately, no done; then start A=8'h01, B=8'h02 -> Sum=8'h03.
REQ-034 With SERIAL_ADD_SUB_EN: Sub=1, A=8'h05, B=8'h07 -> Sum=8'hFE, Ca=0; Sub=1, A=8'h07, B=8'h05 -> Sum=8'h02, Ca=1.
REQ-035 start held high for 30 cycles with fixed A=8'h01, B=8'h01 -> done pulses exactly every 10 cycles, each with Sum=8'h02.
